// File: rtl/ccff_loader_pkg.sv
// Shared types and the serial CRC-8 step used by the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One MSB-first CRC-8 step: feedback is the outgoing MSB xor the new bit.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 accumulator; clear has priority over enable.
module ccff_crc8_serial
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [7:0] crc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc <= 8'h00;
    else if (clear)  crc <= 8'h00;
    else if (enable) crc <= crc8_next(crc, din);
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams configuration words into a CCFF chain, rotates it once for readback,
// and flags a CRC mismatch between the written and read-back bit streams.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clock,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NB_W      = $clog2(WORD_W + 1);
  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WORDS_INI = CNT_W'(NUM_WORDS);
  localparam logic [NB_W-1:0]  NB_FULL   = NB_W'(WORD_W);
  localparam logic [NB_W-1:0]  NB_ONE    = NB_W'(1);

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [NB_W-1:0]   nbits;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  words_left;
  logic [7:0]        crc_wr;
  logic [7:0]        crc_rd;

  logic shifting;
  logic verifying;
  logic take_word;
  logic crc_clear;
  logic last_bit;

  assign shifting  = (state == ST_LOAD) && (nbits != '0);
  assign verifying = (state == ST_VERIFY);
  assign take_word = cfg_ready && cfg_valid;
  assign crc_clear = (state == ST_IDLE) && start;
  assign last_bit  = (bit_cnt == LAST_BIT);

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    config_enable = shifting || verifying;
    if (state == ST_LOAD)
      cfg_ready = ((nbits == '0) || ((nbits == NB_ONE) && shifting)) && (words_left != '0);
    if (shifting)
      ccff_head = sreg[WORD_W-1];
    else if (verifying)
      ccff_head = ccff_tail;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // NOTE: the word buffer is an ordinary register and is reset with everything else.
  always_ff @(posedge prog_clock or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      nbits      <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      error      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            sreg       <= '0;
            nbits      <= '0;
            bit_cnt    <= '0;
            words_left <= WORDS_INI;
            error      <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (shifting) begin
            sreg  <= sreg << 1;
            nbits <= nbits - 1'b1;
            if (last_bit) begin
              // Leftover bits of the final word are dropped here.
              state   <= ST_VERIFY;
              bit_cnt <= '0;
              sreg    <= '0;
              nbits   <= '0;
            end else if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          // A new word lands on the same edge that shifts the last bit of the old one.
          if (take_word) begin
            sreg       <= cfg_data;
            nbits      <= NB_FULL;
            words_left <= words_left - 1'b1;
          end
        end

        ST_VERIFY: begin
          if (last_bit) begin
            state   <= ST_DONE;
            bit_cnt <= '0;
            error   <= (crc8_next(crc_rd, ccff_tail) != crc_wr);
          end else if (bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

  ccff_crc8_serial u_crc_wr (
    .clk    (prog_clock),
    .rst_n  (prog_reset_n),
    .clear  (crc_clear),
    .enable (shifting),
    .din    (ccff_head),
    .crc    (crc_wr)
  );

  ccff_crc8_serial u_crc_rd (
    .clk    (prog_clock),
    .rst_n  (prog_reset_n),
    .clear  (crc_clear),
    .enable (verifying),
    .din    (ccff_tail),
    .crc    (crc_rd)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: each load pushes its expected outcome; a monitor checks it when done pulses.
module tb_ccff_chain_loader;

  localparam int CL = 20;
  localparam int W  = 8;
  localparam int NW = (CL + W - 1) / W;

  logic          prog_clock   = 1'b0;
  logic          prog_reset_n = 1'b0;
  logic          start        = 1'b0;
  logic [W-1:0]  cfg_data     = '0;
  logic          cfg_valid    = 1'b0;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_tail;
  logic          config_enable;
  logic          busy;
  logic          done;
  logic          error;

  // Behavioural chain: first bit written ends up in the MSB.
  logic [CL-1:0] chain = '0;
  logic          force_zero = 1'b0;

  assign ccff_tail = force_zero ? 1'b0 : chain[CL-1];

  always #5 prog_clock = ~prog_clock;

  always @(posedge prog_clock)
    if (config_enable) chain <= {chain[CL-2:0], ccff_head};

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(W)) u_dut (
    .prog_clock    (prog_clock),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .config_enable (config_enable),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_of(input logic [CL-1:0] bits);
    logic [CL+7:0] m;
    m = {bits, 8'h00};
    for (int i = CL + 7; i >= 8; i--)
      if (m[i]) m = m ^ ((CL+8)'(9'h107) << (i - 8));
    return m[7:0];
  endfunction

  typedef struct {
    logic [CL-1:0] chain;
    logic          err;
    int            lat;
    int            hs;
    int            en;
  } exp_t;

  exp_t sb[$];

  // Monitor: counts handshakes/enables per load and checks against the scoreboard at done.
  int cyc = 0;
  int e0 = 0;
  int hs_cnt = 0;
  int en_cnt = 0;

  always @(posedge prog_clock) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge prog_clock);
      if (prog_reset_n) begin
        if (start && !busy) begin
          e0     = cyc + 1;
          hs_cnt = 0;
          en_cnt = 0;
        end
        if (cfg_valid && cfg_ready) hs_cnt++;
        if (config_enable) en_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_latency", 64'(cyc - e0), 64'(e.lat));
            check("handshakes", 64'(hs_cnt), 64'(e.hs));
            check("enable_cycles", 64'(en_cnt), 64'(e.en));
            check("chain_contents", 64'(chain), 64'(e.chain));
            check("error_flag", 64'(error), 64'(e.err));
          end
        end
      end
    end
  end

  // words: word 0 in the top byte. gaps: byte i = idle cycles before word i
  // (for i > 0, counted from the handshake of word i-1).
  task automatic run_load(input logic [NW*W-1:0] words, input logic [NW*8-1:0] gaps,
                          input bit force_err, input bit mid_start);
    exp_t          e;
    int            stalls;
    int            g;
    bit            ok;
    logic [CL-1:0] bits;

    bits   = words[NW*W-1 -: CL];
    stalls = int'(gaps[7:0]);
    for (int i = 1; i < NW; i++) begin
      g = int'(gaps[i*8 +: 8]);
      if (g > W - 1) stalls += g - (W - 1);
    end
    e.chain = force_err ? '0 : bits;
    e.err   = force_err ? (crc_of(bits) != crc_of('0)) : 1'b0;
    e.lat   = 2 * CL + 1 + stalls;
    e.hs    = NW;
    e.en    = 2 * CL;
    sb.push_back(e);

    force_zero = force_err;
    @(posedge prog_clock); #1;
    start     = 1'b1;
    cfg_valid = 1'b0;
    @(posedge prog_clock); #1;
    start = 1'b0;
    check("error_cleared_on_start", 64'(error), 64'd0);

    for (int i = 0; i < NW; i++) begin
      g = int'(gaps[i*8 +: 8]);
      for (int c = 0; c < g; c++) begin
        start = mid_start && (i == 1) && (c == 0);
        @(posedge prog_clock); #1;
      end
      start     = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = words[(NW-1-i)*W +: W];
      ok = 1'b0;
      for (int n = 0; n < 100 && !ok; n++) begin
        @(negedge prog_clock);
        if (cfg_ready) begin
          @(posedge prog_clock);
          ok = 1'b1;
        end
      end
      check("handshake_wait", 64'(ok), 64'd1);
      #1 cfg_valid = 1'b0;
    end

    ok = 1'b0;
    for (int n = 0; n < 4 * CL + 50 && !ok; n++) begin
      @(negedge prog_clock);
      if (done) ok = 1'b1;
    end
    check("done_wait", 64'(ok), 64'd1);
    @(posedge prog_clock); #1;
    force_zero = 1'b0;
  endtask

  function automatic logic [NW*8-1:0] rand_gaps(input bit min_one);
    logic [NW*8-1:0] r;
    for (int i = 0; i < NW; i++) r[i*8 +: 8] = 8'($urandom_range(0, 12));
    if (min_one && r[15:8] == 8'd0) r[15:8] = 8'd1;
    return r;
  endfunction

  initial begin
    logic [7:0] exp_err;
    bit         fe;

    cfg_valid = 1'b1;
    repeat (2) @(posedge prog_clock);
    #1 check("reset_outputs", 64'({cfg_ready, ccff_head, config_enable, busy, done, error}), 64'd0);
    @(negedge prog_clock);
    cfg_valid    = 1'b0;
    prog_reset_n = 1'b1;

    // Partial final word, no stalls.
    run_load(24'hFF00C3, 24'h000000, 1'b0, 1'b0);
    // Three stall cycles after the first word's bits run out.
    run_load(24'($urandom), {8'd0, 8'd10, 8'd0}, 1'b0, 1'b0);
    // Readback forced to zero: mismatch must be flagged and held through IDLE.
    run_load(24'hFF00C3, 24'h000000, 1'b1, 1'b0);
    exp_err = {7'd0, crc_of(20'hFF00C) != 8'h00};
    repeat (3) @(posedge prog_clock);
    #1 check("error_sticky_idle", 64'(error), 64'(exp_err));
    check("idle_not_busy", 64'(busy), 64'd0);
    // start pulsed mid-load is ignored; this load also clears the sticky error.
    run_load(24'($urandom), rand_gaps(1'b1), 1'b0, 1'b1);

    // Reset mid-load.
    @(posedge prog_clock); #1 start = 1'b1;
    @(posedge prog_clock); #1 start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'($urandom);
    repeat (6) @(posedge prog_clock);
    #3 prog_reset_n = 1'b0;
    #1 check("reset_mid_load", 64'({cfg_ready, ccff_head, config_enable, busy, done, error}), 64'd0);
    cfg_valid = 1'b0;
    @(negedge prog_clock);
    prog_reset_n = 1'b1;

    // Full load after the reset, then randomized loads.
    run_load(24'($urandom), 24'h000000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      fe = ($urandom_range(0, 3) == 0);
      run_load(24'($urandom), rand_gaps(1'b0), fe, 1'b0);
    end

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
